// File: rtl/prpg_pkg.sv
// Shared types and default widths for the LFSR pattern Hamming-distance statistics block.
package prpg_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int W_DEF         = 8;
  localparam int SUM_W_DEF     = 7;
  localparam int RUN_W_DEF     = 5;
  localparam int LOG_DEPTH_DEF = 16;

  localparam logic [W_DEF-2:0] MISR_TAPS_DEF = 7'b0100101;

endpackage

// File: rtl/prpg_hd_stats_if.sv
// Pattern stream valid/ready channel between the LFSR source and the statistics block.
interface prpg_hd_stats_if #(
  parameter int W = 8
) ();

  logic         pat_valid;
  logic         pat_ready;
  logic [0:W-1] pat_data;

  modport master (output pat_valid, output pat_data, input pat_ready);
  modport slave  (input pat_valid, input pat_data, output pat_ready);

endinterface

// File: rtl/prpg_seq_div.sv
// Restoring divider, one quotient bit per cycle MSB first; done/quotient are presented
// combinationally in the cycle whose clock edge completes the final bit.
module prpg_seq_div #(
  parameter int DW = 7,
  parameter int VW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int CW = $clog2(DW + 1);

  logic [VW-1:0] rem_q;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  logic [VW:0]   rem_sh;
  logic [VW:0]   diff;
  logic          ge;
  logic [VW-1:0] rem_nx;
  logic [DW-1:0] quo_nx;

  // Borrow out of the trial subtraction decides the quotient bit.
  always_comb begin
    rem_sh = {rem_q, quo_q[DW-1]};
    diff   = rem_sh - {1'b0, div_q};
    ge     = ~diff[VW];
    rem_nx = ge ? diff[VW-1:0] : rem_sh[VW-1:0];
    quo_nx = {quo_q[DW-2:0], ge};
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(DW - 1));
  assign quotient = quo_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend;
      div_q  <= divisor;
    end else if (busy_q) begin
      if (abort || done) begin
        busy_q <= 1'b0;
      end
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/prpg_hd_stats.sv
// Hamming-distance statistics on the LFSR pattern stream with log RAM and average readout.
// Optional MISR signature compiled in with `define PRPG_MISR_EN.
module prpg_hd_stats
  import prpg_pkg::*;
#(
  parameter int               W         = W_DEF,
  parameter int               SUM_W     = SUM_W_DEF,
  parameter int               RUN_W     = RUN_W_DEF,
  parameter int               LOG_DEPTH = LOG_DEPTH_DEF,
  parameter logic [W-2:0]     MISR_TAPS = MISR_TAPS_DEF,
  localparam int              HW        = $clog2(W + 1),
  localparam int              AW        = $clog2(LOG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  prpg_hd_stats_if.slave    pat,
  input  logic              clear,
  input  logic              avg_req,
  output logic              avg_busy,
  output logic              avg_done,
  output logic [SUM_W-1:0]  hd_avg,
  output logic [HW-1:0]     hd_last,
  output logic [SUM_W-1:0]  hd_total,
  output logic [RUN_W-1:0]  run_num,
  input  logic [AW-1:0]     rd_addr,
  output logic [HW-1:0]     rd_data,
  output logic [0:W-1]      signature
);

  localparam int SW1 = SUM_W + 1;

  state_e state_q, state_d;

  logic           accept;
  logic           have_prev_q;
  logic [0:W-1]   prev_q;
  logic [0:W-1]   diff;
  logic [HW-1:0]  hd;
  logic [SW1-1:0] sum_ext;
  logic [AW-1:0]  ptr_q;
  logic [HW-1:0]  log_mem [LOG_DEPTH];

  logic           div_start;
  logic           div_busy;
  logic           div_done;
  logic [SUM_W-1:0] div_quo;

  assign pat.pat_ready = (state_q == ACC) && !clear;
  assign accept        = pat.pat_valid && pat.pat_ready;

  always_comb begin
    diff = prev_q ^ pat.pat_data;
    hd   = '0;
    for (int i = 0; i < W; i++) begin
      hd = hd + HW'(diff[i]);
    end
  end

  assign sum_ext = {1'b0, hd_total} + SW1'(hd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_prev_q <= 1'b0;
      prev_q      <= '0;
      hd_last     <= '0;
      hd_total    <= '0;
      run_num     <= '0;
      ptr_q       <= '0;
    end else if (clear) begin
      have_prev_q <= 1'b0;
      prev_q      <= '0;
      hd_last     <= '0;
      hd_total    <= '0;
      run_num     <= '0;
      ptr_q       <= '0;
    end else if (accept) begin
      prev_q      <= pat.pat_data;
      have_prev_q <= 1'b1;
      if (have_prev_q) begin
        hd_last  <= hd;
        hd_total <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        run_num  <= (run_num == '1) ? run_num : run_num + 1'b1;
        ptr_q    <= ptr_q + 1'b1;
      end
    end
  end

  // Log contents deliberately survive reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (accept && have_prev_q) begin
      log_mem[ptr_q] <= hd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= log_mem[rd_addr];
    end
  end

  assign div_start = (state_q == LOAD) && !clear && (run_num != '0);

  prpg_seq_div #(
    .DW (SUM_W),
    .VW (RUN_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (clear),
    .dividend (hd_total),
    .divisor  (run_num),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:  if (!clear && avg_req) state_d = LOAD;
      LOAD: begin
        if (clear)                state_d = ACC;
        else if (run_num == '0)   state_d = DONE;
        else                      state_d = DIV;
      end
      DIV: begin
        if (clear)                state_d = ACC;
        else if (div_done)        state_d = DONE;
      end
      DONE:                       state_d = ACC;
      default:                    state_d = ACC;
    endcase
  end

  assign avg_busy = (state_q != ACC);
  assign avg_done = (state_q == DONE) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_avg <= '0;
    end else if (!clear) begin
      if (state_q == LOAD && run_num == '0) begin
        hd_avg <= '0;
      end else if (state_q == DIV && div_done && div_busy) begin
        hd_avg <= div_quo;
      end
    end
  end

`ifdef PRPG_MISR_EN
  logic [0:W-1] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (clear) begin
      sig_q <= '0;
    end else if (accept) begin
      sig_q <= {sig_q[W-1], sig_q[0:W-2] ^ (MISR_TAPS & {(W-1){sig_q[W-1]}})} ^ pat.pat_data;
    end
  end

  assign signature = sig_q;
`else
  logic unused_taps;
  assign unused_taps = ^MISR_TAPS;
  assign signature   = '0;
`endif

endmodule

// File: tb/tb_prpg_hd_stats.sv
// Directed bench for prpg_hd_stats: expected averages are queued at request time and
// checked by a monitor on each avg_done pulse; status outputs are checked inline.
module tb_prpg_hd_stats;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       avg_req = 1'b0;
  logic       avg_busy;
  logic       avg_done;
  logic [6:0] hd_avg;
  logic [3:0] hd_last;
  logic [6:0] hd_total;
  logic [4:0] run_num;
  logic [3:0] rd_addr = '0;
  logic [3:0] rd_data;
  logic [0:7] signature;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int avg;
    int cyc;
  } exp_t;
  exp_t sb_q[$];

  prpg_hd_stats_if #(.W(8)) pat_if ();

  prpg_hd_stats dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pat       (pat_if),
    .clear     (clear),
    .avg_req   (avg_req),
    .avg_busy  (avg_busy),
    .avg_done  (avg_done),
    .hd_avg    (hd_avg),
    .hd_last   (hd_last),
    .hd_total  (hd_total),
    .run_num   (run_num),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .signature (signature)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && avg_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_avg_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("hd_avg", int'(hd_avg), e.avg);
        chk("avg_done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic beat(input logic [7:0] d);
    pat_if.pat_valid = 1'b1;
    pat_if.pat_data  = d;
    @(negedge clk);
    pat_if.pat_valid = 1'b0;
  endtask

  task automatic req_avg(input int exp_avg, input int lat);
    exp_t e;
    avg_req = 1'b1;
    e.avg = exp_avg;
    e.cyc = cyc + lat;
    sb_q.push_back(e);
    @(negedge clk);
    avg_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (avg_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(avg_busy), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic read_log(input logic [3:0] a, input int exp);
    rd_addr = a;
    @(negedge clk);
    chk("rd_data", int'(rd_data), exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pat_if.pat_valid = 1'b0;
    pat_if.pat_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_hd_avg", int'(hd_avg), 0);
    chk("rst_hd_total", int'(hd_total), 0);
    chk("rst_run_num", int'(run_num), 0);
    chk("rst_hd_last", int'(hd_last), 0);
    chk("rst_avg_busy", int'(avg_busy), 0);
    chk("rst_signature", int'(signature), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pat_ready", int'(pat_if.pat_ready), 1);

    // first beat only seeds prev
    beat(8'hFF);
    chk("t1_first_run", int'(run_num), 0);
    beat(8'h7F);
    chk("t1_run_num", int'(run_num), 1);
    chk("t1_hd_last", int'(hd_last), 1);
    chk("t1_hd_total", int'(hd_total), 1);
    read_log(4'd0, 1);

    // avg_req in the same cycle as the last beat: beat counted first
    do_clear();
    beat(8'hFF);
    beat(8'h00);
    beat(8'hFF);
    pat_if.pat_valid = 1'b1;
    pat_if.pat_data  = 8'h00;
    req_avg(8, 9);
    pat_if.pat_valid = 1'b0;
    chk("t2_hd_total", int'(hd_total), 24);
    chk("t2_run_num", int'(run_num), 3);
    wait_idle();

    do_clear();
    beat(8'h00);
    beat(8'h0F);
    beat(8'h00);
    chk("t3_hd_total", int'(hd_total), 8);
    chk("t3_run_num", int'(run_num), 2);
    req_avg(4, 9);
    wait_idle();
    do_clear();
    req_avg(0, 2);
    wait_idle();

    // saturation and log wrap
    do_clear();
    for (int i = 0; i < 18; i++) beat((i % 2 == 0) ? 8'hFF : 8'h00);
    chk("t4_run_num", int'(run_num), 17);
    chk("t4_hd_total", int'(hd_total), 127);
    req_avg(7, 9);
    wait_idle();
    beat(8'h0F);
    chk("t4_hd_last", int'(hd_last), 4);
    read_log(4'd0, 8);
    read_log(4'd1, 4);

    // beat held off during the division
    do_clear();
    beat(8'h00);
    beat(8'hFF);
    req_avg(8, 9);
    pat_if.pat_valid = 1'b1;
    pat_if.pat_data  = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_ready_in_div", int'(pat_if.pat_ready), 0);
    end
    chk("t5_run_held", int'(run_num), 1);
    wait_idle();
    chk("t5_ready_back", int'(pat_if.pat_ready), 1);
    @(negedge clk);
    pat_if.pat_valid = 1'b0;
    chk("t5_run_num", int'(run_num), 2);
    chk("t5_hd_total", int'(hd_total), 12);
    chk("t5_hd_last", int'(hd_last), 4);

    // clear aborts a running division
    avg_req = 1'b1;
    @(negedge clk);
    avg_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_busy_div", int'(avg_busy), 1);
    do_clear();
    chk("t5_abort_busy", int'(avg_busy), 0);
    repeat (12) @(negedge clk);
    chk("t5_abort_hd_avg", int'(hd_avg), 8);

    // reset mid-operation
    beat(8'h00);
    beat(8'hFF);
    avg_req = 1'b1;
    @(negedge clk);
    avg_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", int'(avg_busy), 0);
    chk("t6_rst_hd_avg", int'(hd_avg), 0);
    chk("t6_rst_run", int'(run_num), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(8'h01);
    beat(8'h02);
    chk("t6_run_num", int'(run_num), 1);
    chk("t6_hd_total", int'(hd_total), 2);
`ifdef PRPG_MISR_EN
    chk("t6_signature", int'(signature), 8'hA7);
`else
    chk("t6_signature", int'(signature), 0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
